// File: rtl/tree_adder_pkg.sv
// rtl/tree_adder_pkg.sv - shared widths and sizing helper for the tree adder
package tree_adder_pkg;

    localparam int WAB_DEFAULT = 4;
    localparam int WCD_DEFAULT = 8;

    // Two extra bits: one per adder level, so the final sum can never wrap.
    function automatic int sum_width(input int wab, input int wcd);
        return ((wab > wcd) ? wab : wcd) + 2;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - registered unsigned adder with valid pass-through
module adder_stage #(
    parameter int WA = 4,
    parameter int WB = 4,
    parameter int WO = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic [WO-1:0] y,
    output logic          out_valid
);

    // Data registers run every cycle; the valid bit only qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            y         <= WO'(a) + WO'(b);
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/tree_adder_procedural.sv
// rtl/tree_adder_procedural.sv - two-level pipelined adder tree (a+b)+(c+d)
module tree_adder_procedural
    import tree_adder_pkg::*;
#(
    parameter int WAB = WAB_DEFAULT,
    parameter int WCD = WCD_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [WAB-1:0]                   a,
    input  logic [WAB-1:0]                   b,
    input  logic [WCD-1:0]                   c,
    input  logic [WCD-1:0]                   d,
    output logic [WAB:0]                     sum1,
    output logic [WCD:0]                     sum2,
    output logic [sum_width(WAB, WCD)-1:0]   sum,
    output logic                             mid_valid,
    output logic                             out_valid
);

    localparam int WS = sum_width(WAB, WCD);

    logic valid_ab;
    logic valid_cd;

    adder_stage #(.WA(WAB), .WB(WAB), .WO(WAB + 1)) u_stage_ab (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .y         (sum1),
        .out_valid (valid_ab)
    );

    adder_stage #(.WA(WCD), .WB(WCD), .WO(WCD + 1)) u_stage_cd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (c),
        .b         (d),
        .y         (sum2),
        .out_valid (valid_cd)
    );

    // Both first-level valids are identical copies of in_valid delayed once.
    assign mid_valid = valid_ab & valid_cd;

    adder_stage #(.WA(WAB + 1), .WB(WCD + 1), .WO(WS)) u_stage_sum (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mid_valid),
        .a         (sum1),
        .b         (sum2),
        .y         (sum),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_tree_adder_procedural.sv
// tb/tb_tree_adder_procedural.sv - directed self-checking bench for tree_adder_procedural
module tb_tree_adder_procedural;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [4:0] sum1;
    logic [8:0] sum2;
    logic [9:0] sum;
    logic       mid_valid;
    logic       out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    tree_adder_procedural #(.WAB(4), .WCD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .sum1      (sum1),
        .sum2      (sum2),
        .sum       (sum),
        .mid_valid (mid_valid),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int va, input int vb, input int vc, input int vd);
        in_valid = v;
        a = 4'(va);
        b = 4'(vb);
        c = 8'(vc);
        d = 8'(vd);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 15, 15, 255, 255);
        step();
        step();
        check("rst_sum1", 32'(sum1), 0);
        check("rst_sum2", 32'(sum2), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_mid_valid", 32'(mid_valid), 0);
        check("rst_out_valid", 32'(out_valid), 0);

        // Basic set followed immediately by the back-to-back set
        rst = 1'b0;
        drive(1'b1, 2, 8, 20, 32);
        step();
        check("basic_sum1", 32'(sum1), 10);
        check("basic_sum2", 32'(sum2), 52);
        check("basic_mid_valid", 32'(mid_valid), 1);
        drive(1'b1, 2, 8, 15, 25);
        step();
        check("basic_sum", 32'(sum), 62);
        check("basic_out_valid", 32'(out_valid), 1);
        check("b2b_sum2", 32'(sum2), 40);
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("b2b_sum", 32'(sum), 50);
        check("b2b_out_valid", 32'(out_valid), 1);
        check("b2b_mid_idle", 32'(mid_valid), 0);
        step();
        check("b2b_out_idle", 32'(out_valid), 0);

        // Maximum operands: no wrap
        drive(1'b1, 15, 15, 255, 255);
        step();
        check("max_sum1", 32'(sum1), 30);
        check("max_sum2", 32'(sum2), 510);
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("max_sum", 32'(sum), 540);
        check("max_out_valid", 32'(out_valid), 1);

        // All-zero operands still produce a valid result
        drive(1'b1, 0, 0, 0, 0);
        step();
        check("zero_sum1", 32'(sum1), 0);
        check("zero_sum2", 32'(sum2), 0);
        check("zero_mid_valid", 32'(mid_valid), 1);
        drive(1'b0, 7, 7, 7, 7);
        step();
        check("zero_sum", 32'(sum), 0);
        check("zero_out_valid", 32'(out_valid), 1);

        // Reset mid-flight discards the basic set
        drive(1'b1, 2, 8, 20, 32);
        step();
        check("midrst_pre_sum1", 32'(sum1), 10);
        rst = 1'b1;
        step();
        check("midrst_sum1", 32'(sum1), 0);
        check("midrst_sum2", 32'(sum2), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_mid_valid", 32'(mid_valid), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("midrst_after_sum", 32'(sum), 0);
        check("midrst_after_out_valid", 32'(out_valid), 0);
        step();
        check("midrst_after2_sum", 32'(sum), 0);
        check("midrst_after2_out_valid", 32'(out_valid), 0);

        // Valid gaps 1,0,1
        drive(1'b1, 1, 2, 3, 4);
        step();
        drive(1'b0, 5, 5, 5, 5);
        step();
        check("gap0_sum", 32'(sum), 10);
        check("gap0_out_valid", 32'(out_valid), 1);
        drive(1'b1, 3, 3, 100, 100);
        step();
        check("gap1_sum", 32'(sum), 20);
        check("gap1_out_valid", 32'(out_valid), 0);
        drive(1'b0, 0, 0, 0, 0);
        step();
        check("gap2_sum", 32'(sum), 206);
        check("gap2_out_valid", 32'(out_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
